mod_n_updown_counter: RTL

Runtime-programmable modulo counter. It counts up or down with enable, and its modulus can be changed on the fly through a shadow register that takes effect only at a wrap boundary, so the sequence is never broken mid-cycle. It is the next-generation replacement for the fixed-modulus counter in the counter/timer library. Typical users are clock dividers, cascaded timers and round-robin index generators.

---
 rtl/mod_n_updown_counter.sv | 92 +++++++++
 1 files changed

// File: rtl/mod_n_updown_counter.sv
// Runtime-programmable modulo-M up/down counter with a shadow modulus committed at wrap edges.
// Optional synchronous load port compiled in with `define MOD_CNT_LOAD_EN.
module mod_n_updown_counter #(
   parameter int N_MAX     = 16,
   parameter int RESET_MOD = N_MAX,
   localparam int W        = $clog2(N_MAX),
   localparam int MW       = $clog2(N_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          up,
   input  logic          mod_wr,
   input  logic [MW-1:0] mod_val,
`ifdef MOD_CNT_LOAD_EN
   input  logic          load,
   input  logic [W-1:0]  load_val,
`endif
   output logic [W-1:0]  Q,
   output logic          tc,
   output logic          wrap,
   output logic [MW-1:0] mod_act,
   output logic          mod_err
);

   // One extra bit of headroom so M-1 and comparisons against M never overflow.
   localparam int XW = MW + 1;
   localparam logic [MW-1:0] RST_M = MW'(RESET_MOD);

   logic [MW-1:0] shadow;
   logic [MW-1:0] m_new;
   logic [XW-1:0] q_x, m_x, m_new_x, val_x;
   logic          mod_ok, wrap_up, wrap_dn, wrap_evt, ld;
   logic [W-1:0]  q_nxt;

`ifdef MOD_CNT_LOAD_EN
   function automatic logic [W-1:0] sat_load(input logic [W-1:0] v, input logic [XW-1:0] m);
      if (XW'(v) >= m) return W'(m - XW'(1));
      return v;
   endfunction

   assign ld = load;
`else
   assign ld = 1'b0;
`endif

   assign q_x     = XW'(Q);
   assign m_x     = XW'(mod_act);
   assign val_x   = XW'(mod_val);
   assign mod_ok  = mod_wr && (val_x >= XW'(2)) && (val_x <= XW'(N_MAX));
   // A valid write in the wrap cycle bypasses the shadow and commits directly.
   assign m_new   = mod_ok ? mod_val : shadow;
   assign m_new_x = XW'(m_new);

   // Up-wrap also catches an out-of-range Q so the next up-step returns to 0.
   assign wrap_up  = up && (q_x >= m_x - XW'(1));
   assign wrap_dn  = !up && (q_x == '0);
   assign wrap_evt = !ld && en && (wrap_up || wrap_dn);

   assign tc = en && (up ? (q_x == m_x - XW'(1)) : (q_x == '0));

   always_comb begin
      q_nxt = Q;
`ifdef MOD_CNT_LOAD_EN
      if (load) q_nxt = sat_load(load_val, m_x);
      else
`endif
      if (en) begin
         if (wrap_up)      q_nxt = '0;
         else if (up)      q_nxt = W'(q_x + XW'(1));
         else if (wrap_dn) q_nxt = W'(m_new_x - XW'(1));
         else              q_nxt = W'(q_x - XW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Q       <= '0;
         mod_act <= RST_M;
         shadow  <= RST_M;
         wrap    <= 1'b0;
         mod_err <= 1'b0;
      end else begin
         Q       <= q_nxt;
         wrap    <= wrap_evt;
         mod_err <= mod_wr && !mod_ok;
         if (mod_ok)   shadow  <= mod_val;
         if (wrap_evt) mod_act <= m_new;
      end
   end

endmodule
